// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, data width and clock-counter width.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_CNT_W     = 14;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_PARITY  = 3'd3,
      ST_STOP    = 3'd4,
      ST_CLEANUP = 3'd5
   } tx_state_e;

   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with registered full/empty flags; pointers carry an extra wrap bit.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int W          = UART_DATA_BITS
) (
   input  logic         i_Clock,
   input  logic         i_Rst_n,
   input  logic         i_Push,
   input  logic [W-1:0] i_Data,
   input  logic         i_Pop,
   output logic [W-1:0] o_Data,
   output logic         o_Full,
   output logic         o_Empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [W-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic         full_q, full_d, empty_q, empty_d;
   logic         do_push, do_pop;

   assign do_push = i_Push && !full_q;
   assign do_pop  = i_Pop && !empty_q;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
      // Same index with differing wrap bits means the writer lapped the reader.
      full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
      empty_d = (wptr_d == rptr_d);
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= i_Data;
   end

   assign o_Data  = mem_q[rptr_q[AW-1:0]];
   assign o_Full  = full_q;
   assign o_Empty = empty_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: 8N1 frames fed from a byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Tx_DV,
   input  logic [7:0] i_Tx_Byte,
   output logic       o_Tx_Ready,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Active,
   output logic       o_Tx_Done,
   output logic       o_Tx_Empty
);

   localparam logic [UART_CNT_W-1:0] CNT_LAST = UART_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [UART_CNT_W-1:0] CNT_ONE  = UART_CNT_W'(1);
   localparam logic [2:0]            BIT_LAST = 3'(UART_DATA_BITS - 1);

   tx_state_e                 state_q;
   logic [UART_CNT_W-1:0]     clk_cnt_q;
   logic [2:0]                bit_idx_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic                      serial_q, active_q, done_q, empty_q;

   logic [UART_DATA_BITS-1:0] fifo_data;
   logic                      fifo_full, fifo_empty;
   logic                      push, pop, cnt_done;

   assign push     = i_Tx_DV && !fifo_full;
   assign pop      = (state_q == ST_IDLE) && !fifo_empty;
   assign cnt_done = (clk_cnt_q == CNT_LAST);

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .W          (UART_DATA_BITS)
   ) u_fifo (
      .i_Clock (i_Clock),
      .i_Rst_n (i_Rst_n),
      .i_Push  (push),
      .i_Data  (i_Tx_Byte),
      .i_Pop   (pop),
      .o_Data  (fifo_data),
      .o_Full  (fifo_full),
      .o_Empty (fifo_empty)
   );

   // Line outputs follow the state by one cycle, so a pop at edge N+1 drives the start bit after N+2.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q   <= ST_IDLE;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         serial_q  <= 1'b1;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
         empty_q   <= 1'b1;
      end else begin
         done_q  <= 1'b0;
         empty_q <= fifo_empty && (state_q == ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               serial_q  <= 1'b1;
               active_q  <= 1'b0;
               clk_cnt_q <= '0;
               bit_idx_q <= '0;
               if (pop) begin
                  shift_q <= fifo_data;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               serial_q <= 1'b0;
               active_q <= 1'b1;
               if (cnt_done) begin
                  clk_cnt_q <= '0;
                  state_q   <= ST_DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end
            ST_DATA: begin
               serial_q <= shift_q[bit_idx_q];
               active_q <= 1'b1;
               if (cnt_done) begin
                  clk_cnt_q <= '0;
                  if (bit_idx_q == BIT_LAST) begin
                     bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                     state_q   <= ST_PARITY;
`else
                     state_q   <= ST_STOP;
`endif
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               serial_q <= even_parity(shift_q);
               active_q <= 1'b1;
               if (cnt_done) begin
                  clk_cnt_q <= '0;
                  state_q   <= ST_STOP;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end
`endif
            ST_STOP: begin
               serial_q <= 1'b1;
               active_q <= 1'b1;
               if (cnt_done) begin
                  clk_cnt_q <= '0;
                  state_q   <= ST_CLEANUP;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end
            ST_CLEANUP: begin
               serial_q <= 1'b1;
               active_q <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= ST_IDLE;
            end
            default: begin
               serial_q <= 1'b1;
               active_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_Tx_Ready  = !fifo_full;
   assign o_Tx_Serial = serial_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Done   = done_q;
   assign o_Tx_Empty  = empty_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed frame timing plus random traffic through a loopback receiver model.
module tb_uart_tx_buffered;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       dv;
   logic [7:0] tx_byte;
   logic       ready, ser, act, done, empty;

   always #5 clk = ~clk;

   uart_tx_buffered #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Tx_DV     (dv),
      .i_Tx_Byte   (tx_byte),
      .o_Tx_Ready  (ready),
      .o_Tx_Serial (ser),
      .o_Tx_Active (act),
      .o_Tx_Done   (done),
      .o_Tx_Empty  (empty)
   );

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;

   logic [7:0] exp_q [$];
   logic [7:0] rx_q  [$];
   int         frame_err = 0;
   int         done_cnt  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected line level for frame bit idx: start, 8 data LSB first, [even parity], stop.
   function automatic logic exp_bit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   // Loopback receiver: finds the start edge, samples mid-bit, checks framing.
   initial begin : rx_mon
      bit         busy;
      int         t;
      logic [10:0] bits;
      logic [7:0]  d;
      busy = 0;
      t    = 0;
      bits = '0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            busy = 0;
         end else begin
            if (done === 1'b1) done_cnt++;
            if (!busy) begin
               if (ser === 1'b0) begin
                  busy = 1;
                  t    = 0;
               end
            end else begin
               t++;
            end
            if (busy && (t % CPB) == CPB / 2) begin
               bits[t / CPB] = ser;
               if (t / CPB == NB - 1) begin
                  d = bits[8:1];
                  if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1) frame_err++;
`ifdef UART_TX_PARITY_EN
                  if (bits[9] !== ^d) frame_err++;
`endif
                  rx_q.push_back(d);
                  busy = 0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) until every expected byte has arrived, then compare in order.
   task automatic expect_all(input int budget);
      int n;
      int t;
      n = exp_q.size();
      t = 0;
      while (rx_q.size() < n && t < budget) begin
         tick();
         t++;
      end
      check("rx_count", rx_q.size(), n);
      while (exp_q.size() > 0 && rx_q.size() > 0)
         check("rx_byte", rx_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
   endtask

   // Called idle with an empty FIFO: push at edge N, line low from after N+2, done after the last stop cycle.
   task automatic send_frame_timed(input logic [7:0] d);
      tx_byte = d;
      dv      = 1'b1;
      tick();
      dv = 1'b0;
      exp_q.push_back(d);
      check("lat_edge_n", ser, 1);
      tick();
      check("lat_edge_n1", {ser, act}, 2'b10);
      tick();
      for (int j = 0; j < NB * CPB; j++) begin
         check("frame_bit", {ser, act, done}, {exp_bit(d, j / CPB), 1'b1, 1'b0});
         tick();
      end
      check("done_pulse", {ser, act, done}, 3'b101);
      tick();
      check("done_clear", done, 0);
   endtask

   initial begin : main
      int         cyc;
      int         i;
      int         d0;
      bit         acc;
      logic       prev_done;
      logic [7:0] burst [5];
      burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'hA5; burst[3] = 8'h3C; burst[4] = 8'h81;

      rst_n   = 1'b0;
      dv      = 1'b0;
      tx_byte = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {ser, act, done, ready, empty}, 5'b10011);
      rst_n = 1'b1;

      // Idle line: nothing pushed for 200 cycles.
      for (int k = 0; k < 200; k++) begin
         tick();
         check("idle_line", {ser, act, done}, 3'b100);
      end

      send_frame_timed(8'h55);
      expect_all(100);
      send_frame_timed(8'h07);
      send_frame_timed(8'h03);
      send_frame_timed(8'($urandom));
      expect_all(100);
      check("idle_empty", empty, 1);

      // Back-to-back burst: 5 accepted in 5 consecutive cycles, then full.
      d0  = done_cnt;
      cyc = 0;
      i   = 0;
      while (i < 5 && cyc < 20) begin
         tx_byte = burst[i];
         dv      = 1'b1;
         acc     = ready;
         tick();
         cyc++;
         if (acc) begin
            exp_q.push_back(burst[i]);
            i++;
         end
      end
      check("burst_cycles", cyc, 5);
      check("burst_full", {ready, empty}, 2'b00);

      // Hold a 6th byte while full; it must go in the cycle after the next pop.
      tx_byte   = 8'h77;
      prev_done = 1'b0;
      cyc       = 0;
      while (!ready && cyc < 200) begin
         prev_done = done;
         tick();
         cyc++;
      end
      check("ready_reopen", ready, 1);
      check("pop_after_done", prev_done, 1);
      tick();
      exp_q.push_back(8'h77);
      dv = 1'b0;
      check("refull", ready, 0);
      expect_all(600);
      cyc = 0;
      while (!empty && cyc < 100) begin
         tick();
         cyc++;
      end
      check("drain_empty", empty, 1);
      check("burst_done_cnt", done_cnt - d0, 6);

      // Reset mid-DATA of 0xC3 with 0xEE queued behind it.
      tx_byte = 8'hC3;
      dv      = 1'b1;
      tick();
      tx_byte = 8'hEE;
      tick();
      dv = 1'b0;
      tick();
      repeat (13) tick();
      check("c3_bit2_low", {ser, act}, 2'b01);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_frame", {ser, act, done, ready, empty}, 5'b10011);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 60; k++) begin
         tick();
         check("post_rst_idle", {ser, act}, 2'b10);
      end
      check("rst_no_rx", rx_q.size(), 0);
      send_frame_timed(8'h12);
      expect_all(100);

      // Random traffic with random gaps.
      for (int r = 0; r < 10; r++) begin
         repeat ($urandom_range(0, 3)) tick();
         tx_byte = 8'($urandom);
         dv      = 1'b1;
         cyc     = 0;
         acc     = 1'b0;
         while (!acc && cyc < 200) begin
            acc = ready;
            tick();
            cyc++;
            if (acc) exp_q.push_back(tx_byte);
         end
         dv = 1'b0;
         check("rand_accept", acc, 1);
      end
      expect_all(3000);
      check("frame_errors", frame_err, 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
